// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : unified_mem_arbiter
// Brief    : Shares one single-port instruction/data memory between the IF
//            fetch port and the MEM load/store port. MEM has priority, and
//            an anti-starvation counter guarantees that IF makes progress.
// Revision : 1.0 - initial release
// ==========================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_ack   = 2'd3;

    localparam logic [3:0] c_mem_lat    = 4'(MEM_LAT);
    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic              w_grant_if;
    logic              w_grant_mem;
    logic              w_capture;

    logic              r_owner_mem;
    logic [3:0]        r_starve_cnt;
    logic [3:0]        r_lat_cnt;
    logic              r_m_en;
    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_wdata;
    logic              r_if_ack;
    logic              r_mem_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_busy;

    always_comb begin
        w_state_next = r_state;
        w_grant_if   = 1'b0;
        w_grant_mem  = 1'b0;
        case (r_state)
            c_st_idle: begin
                // IF wins a tie only once MEM has starved it STARVE_MAX times
                if (mem_req && (!if_req || (r_starve_cnt != c_starve_max))) begin
                    w_grant_mem = 1'b1;
                end else if (if_req) begin
                    w_grant_if = 1'b1;
                end
                if (w_grant_mem || w_grant_if) begin
                    w_state_next = c_st_issue;
                end
            end
            c_st_issue: w_state_next = c_st_wait;
            c_st_wait: begin
                if (r_lat_cnt == c_mem_lat) begin
                    w_state_next = c_st_ack;
                end
            end
            c_st_ack:  w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    assign w_capture = (r_state == c_st_wait) && (r_lat_cnt == c_mem_lat);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner_mem  <= 1'b0;
            r_starve_cnt <= 4'd0;
            r_lat_cnt    <= 4'd0;
            r_m_en       <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_m_en    <= (w_state_next == c_st_issue);
            r_busy    <= (w_state_next != c_st_idle);
            r_if_ack  <= (w_state_next == c_st_ack) && !r_owner_mem;
            r_mem_ack <= (w_state_next == c_st_ack) && r_owner_mem;

            if (w_grant_mem || w_grant_if) begin
                r_owner_mem <= w_grant_mem;
                r_m_we      <= w_grant_mem && mem_we;
                r_m_addr    <= w_grant_mem ? mem_addr : if_addr;
                r_m_wdata   <= w_grant_mem ? mem_wdata : '0;
            end

            if (w_grant_mem && if_req) begin
                if (r_starve_cnt < c_starve_max) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else if (w_grant_mem || w_grant_if) begin
                r_starve_cnt <= 4'd0;
            end

            if (r_state == c_st_issue) begin
                r_lat_cnt <= 4'd1;
            end else if ((r_state == c_st_wait) && (r_lat_cnt < c_mem_lat)) begin
                r_lat_cnt <= r_lat_cnt + 4'd1;
            end

            // Stores complete with zero read data
            if (w_capture) begin
                if (r_owner_mem) begin
                    r_mem_rdata <= r_m_we ? '0 : m_rdata;
                end else begin
                    r_if_rdata <= m_rdata;
                end
            end
        end
    end

    assign m_en      = r_m_en;
    assign m_we      = r_m_we;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;
    assign if_ack    = r_if_ack;
    assign mem_ack   = r_mem_ack;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// Module   : tb_unified_mem_arbiter
// Brief    : Directed vector bench for unified_mem_arbiter (MEM_LAT=1 and 4).
// Revision : 1.0 - initial release
// ==========================================================================
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
    logic [31:0] m_rdata;
    logic        if_ack, mem_ack, m_en, m_we, busy;

    logic        d4_mem_req;
    logic [31:0] d4_mem_addr;
    logic [31:0] d4_if_rdata, d4_mem_rdata, d4_m_addr, d4_m_wdata, d4_m_rdata;
    logic        d4_if_ack, d4_mem_ack, d4_m_en, d4_m_we, d4_busy;

    int n_pass  = 0;
    int n_total = 0;
    int b2b     = 0;
    int ovl     = 0;
    logic prev_en = 1'b0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4), .STARVE_MAX(3)) dut4 (
        .clk(clk), .reset(reset),
        .if_req(1'b0), .if_addr(32'h0), .if_rdata(d4_if_rdata), .if_ack(d4_if_ack),
        .mem_req(d4_mem_req), .mem_we(1'b0), .mem_addr(d4_mem_addr), .mem_wdata(32'h0),
        .mem_rdata(d4_mem_rdata), .mem_ack(d4_mem_ack),
        .m_en(d4_m_en), .m_we(d4_m_we), .m_addr(d4_m_addr), .m_wdata(d4_m_wdata),
        .m_rdata(d4_m_rdata), .busy(d4_busy)
    );

    // Latency-1 memory model; m_rdata carries garbage except in the valid cycle
    bit [31:0] mem [256];
    bit        written [256];
    logic [15:0] gcnt = 16'h0;

    function automatic logic [31:0] preset(input logic [7:0] idx);
        case (idx)
            8'd4:    return 32'h0050_0093;
            8'd8:    return 32'h1111_2222;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        gcnt <= gcnt + 16'd1;
        if (m_en && m_we) begin
            mem[m_addr[9:2]]     <= m_wdata;
            written[m_addr[9:2]] <= 1'b1;
        end
        if (m_en && !m_we)
            m_rdata <= written[m_addr[9:2]] ? mem[m_addr[9:2]] : preset(m_addr[9:2]);
        else
            m_rdata <= {16'hBAD0, gcnt};
    end

    // Latency-4 source: valid word only in the 4th cycle after m_en
    int d4_since = 0;
    always @(posedge clk) begin
        if (d4_m_en) d4_since <= 1;
        else if (d4_since != 0) d4_since <= d4_since + 1;
    end
    assign d4_m_rdata = (d4_since == 4) ? 32'hCAFE_F00D : {16'h0BAD, 16'(d4_since)};

    always @(negedge clk) begin
        if (m_en && prev_en) b2b++;
        if (if_ack && mem_ack) ovl++;
        prev_en = m_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct packed {
        logic        ifr;
        logic [31:0] ifa;
        logic        mr;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] md;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic        ia;
        logic        mk;
        logic        bz;
        logic [31:0] ird;
        logic [31:0] mrd;
    } vec_t;

    function automatic vec_t mk(input logic ifr, input logic [31:0] ifa, input logic mr,
                                input logic mw, input logic [31:0] ma, input logic [31:0] md,
                                input logic en, input logic we, input logic [31:0] addr,
                                input logic ia, input logic mk_, input logic bz,
                                input logic [31:0] ird, input logic [31:0] mrd);
        vec_t v;
        v = '{ifr, ifa, mr, mw, ma, md, en, we, addr, ia, mk_, bz, ird, mrd};
        return v;
    endfunction

    vec_t        tbl [13];
    logic [31:0] exp_word;
    logic [31:0] d4_data;
    int          en_c, ack_c, nack, last_c;
    logic        exp_own [8];

    initial begin
        // Each row: inputs applied this cycle, outputs expected after the next edge
        tbl[0]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 32'h10,  1'b0, 1'b0, 1'b1, 32'h0,          32'h0);
        tbl[1]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h0,          32'h0);
        tbl[2]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h0050_0093,  32'h0);
        tbl[3]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0050_0093,  32'h0);
        tbl[4]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0050_0093,  32'h0);
        tbl[5]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'h12345678, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h0050_0093,  32'h0);
        tbl[6]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'h12345678, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0050_0093,  32'h0);
        tbl[7]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 32'h12345678, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0050_0093,  32'h0);
        tbl[8]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'h0050_0093,  32'h0);
        tbl[9]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 32'h0050_0093,  32'h0);
        tbl[10] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h0050_0093,  32'hDEADBEEF);
        tbl[11] = mk(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0050_0093,  32'hDEADBEEF);
        tbl[12] = mk(1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0050_0093,  32'hDEADBEEF);
        exp_own = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        d4_mem_req = 1'b0; d4_mem_addr = 32'h0;
        tick(); tick();
        check("reset_state", {m_en, m_we, if_ack, mem_ack, busy, m_addr, m_wdata, if_rdata},
              128'h0);

        // MEM_LAT=4 read: m_en in cycle 1, ack in cycle 6
        reset = 1'b0;
        d4_mem_req = 1'b1; d4_mem_addr = 32'h40;
        en_c = -1; ack_c = -1; d4_data = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (d4_m_en && en_c < 0) en_c = c;
            if (d4_mem_ack && ack_c < 0) begin
                ack_c = c; d4_data = d4_mem_rdata; d4_mem_req = 1'b0;
            end
        end
        check("lat4_m_en_cycle", 128'(en_c), 128'(1));
        check("lat4_ack_cycle", 128'(ack_c), 128'(6));
        check("lat4_rdata", {96'h0, d4_data}, {96'h0, 32'hCAFE_F00D});
        check("lat4_idle_after", {d4_if_ack, d4_mem_ack, d4_busy, d4_m_en}, 128'h0);

        for (int i = 0; i < 13; i++) begin
            if_req = tbl[i].ifr; if_addr = tbl[i].ifa;
            mem_req = tbl[i].mr; mem_we = tbl[i].mw;
            mem_addr = tbl[i].ma; mem_wdata = tbl[i].md;
            tick();
            check($sformatf("vec%0d", i),
                  {27'h0, m_en, (tbl[i].en ? m_we : 1'b0), (tbl[i].en ? m_addr : 32'h0),
                   if_ack, mem_ack, busy, if_rdata, mem_rdata},
                  {27'h0, tbl[i].en, tbl[i].we, tbl[i].addr,
                   tbl[i].ia, tbl[i].mk, tbl[i].bz, tbl[i].ird, tbl[i].mrd});
        end

        // Contention: both ports request continuously
        if_req = 1'b1; if_addr = 32'h10;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100;
        nack = 0; last_c = 0;
        for (int c = 1; c <= 64 && nack < 8; c++) begin
            tick();
            if (if_ack || mem_ack) begin
                exp_word = exp_own[nack] ? 32'hDEADBEEF : 32'h0050_0093;
                check($sformatf("contend_ack%0d", nack),
                      {95'h0, mem_ack, (mem_ack ? mem_rdata : if_rdata)},
                      {95'h0, exp_own[nack], exp_word});
                if (nack > 0) check($sformatf("contend_gap%0d", nack), 128'(c - last_c), 128'(4));
                last_c = c;
                nack++;
            end
        end
        check("contend_done", 128'(nack), 128'(8));
        if_req = 1'b0; mem_req = 1'b0;
        tick();

        // IF drops its request during ISSUE; the transaction still completes
        if_req = 1'b1; if_addr = 32'h20;
        tick();
        check("drop_issue", {95'h0, m_en, m_addr}, {95'h0, 1'b1, 32'h20});
        if_req = 1'b0;
        tick(); tick();
        check("drop_ack", {95'h0, if_ack, if_rdata}, {95'h0, 1'b1, 32'h1111_2222});
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("drop_idle%0d", k), {m_en, busy, if_ack}, 128'h0);
        end

        // Reset in WAIT drops the transaction; held if_req is re-granted
        if_req = 1'b1; if_addr = 32'h10;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rst_wait", {m_en, m_we, if_ack, mem_ack, busy, m_addr, m_wdata, if_rdata, mem_rdata},
              128'h0);
        reset = 1'b0;
        tick();
        check("rst_regrant", {94'h0, m_en, if_ack, m_addr}, {94'h0, 1'b1, 1'b0, 32'h10});
        tick();
        check("rst_no_ack", {if_ack, mem_ack}, 128'h0);
        tick();
        check("rst_ack", {95'h0, if_ack, if_rdata}, {95'h0, 1'b1, 32'h0050_0093});
        if_req = 1'b0;
        tick(); tick();

        check("m_en_never_b2b", 128'(b2b), 128'(0));
        check("acks_never_overlap", 128'(ovl), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified instruction/data memory between the pipeline's IF-stage fetch port and MEM-stage load/store port.
- Grants one transaction at a time and sequences the memory's fixed read latency.
- Returns one-cycle acks; the pipeline holds the requesting stage stalled until its ack arrives.
- MEM has priority, with an anti-starvation counter that guarantees IF forward progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from m_en cycle to m_rdata valid (legal 1..8)
- STARVE_MAX, 3, consecutive MEM grants while IF waits before IF is forced (legal 1..15)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched word, valid when if_ack
- if_ack  out  1  one-cycle completion pulse
- mem_req  in  1  load/store request, held until mem_ack
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid when mem_ack (0 for stores)
- mem_ack  out  1  one-cycle completion pulse
- m_en  out  1  memory access strobe, exactly one cycle per transaction
- m_we  out  1  memory write enable, qualified by m_en
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after m_en cycle
- busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- Reset (any state, mid-transaction included):
  - state=IDLE; m_en, m_we, if_ack, mem_ack, busy = 0.
  - m_addr, m_wdata, if_rdata, mem_rdata = 0; starve_cnt=0; lat_cnt=0.
  - An in-flight transaction is dropped and no ack is issued.
- IDLE arbitration, sampled each edge:
  - Neither requests: stay IDLE.
  - One requests: grant it.
  - Both request: grant MEM unless starve_cnt==STARVE_MAX, then grant IF.
  - On grant: latch owner, address, wdata and we (forced 0 for IF); go to ISSUE.
- starve_cnt (width 4), updated only on grants:
  - MEM granted while if_req=1: starve_cnt+1.
  - IF granted: starve_cnt=0.
  - MEM granted while if_req=0: starve_cnt=0.
  - Never exceeds STARVE_MAX.
- ISSUE (1 cycle): m_en=1, m_we/m_addr/m_wdata = latched values; lat_cnt=1. Next state is WAIT.
- WAIT: m_en=0.
  - While lat_cnt<MEM_LAT: lat_cnt+1.
  - When lat_cnt==MEM_LAT: capture m_rdata (reads) or 0 (stores) into the owner's rdata; go to ACK.
- ACK (1 cycle): owner's ack=1, other ack=0; next state IDLE.
  - rdata holds its value until the next ack for that port.
- Timing: req first high in cycle 0 gives m_en in cycle 1 and ack in cycle 2+MEM_LAT. Back-to-back transactions occur every MEM_LAT+3 cycles.
- Requesters update req/addr in the cycle after ack. IDLE in that cycle treats a still-high req as a new transaction.
- Protocol violations:
  - req dropped before ack: the granted transaction still completes and acks.
  - Inputs changing after grant: ignored, latched copies are used.
- Stores use the same latency as loads. if_ack and mem_ack are never high together. m_en is never high in two consecutive cycles.

Test Plan:
- Reset, then IF read only: if_req=1, if_addr=0x10, memory returns 0x00500093 with MEM_LAT=1 -> m_en in cycle 1 with m_addr=0x10; if_ack in cycle 3 with if_rdata=0x00500093; busy high in cycles 1-3.
- Store then load, MEM only: mem_we=1, addr=0x100, wdata=0xDEADBEEF -> m_en=1, m_we=1 once; mem_ack with mem_rdata=0. Follow with a load of 0x100 -> mem_rdata=0xDEADBEEF.
- Contention, STARVE_MAX=3, both requesting continuously -> grant order MEM,MEM,MEM,IF,MEM,MEM,MEM,IF; acks never overlap; ack spacing is 4 cycles at MEM_LAT=1.
- MEM_LAT=4 read -> ack exactly 6 cycles after req first seen; m_rdata is sampled only in the 4th cycle after m_en; garbage on m_rdata in other cycles is not reflected in rdata.
- Reset asserted in WAIT -> next cycle all outputs 0 and state IDLE; no ack for the dropped transaction. After reset deassert, a held if_req is re-granted normally.
- if_req dropped in ISSUE cycle -> if_ack still pulses at the normal cycle. The next IDLE with no req stays idle and m_en stays 0.
